alu_serial: RTL and testbench
=============================

Name: alu_serial

Overview:
- Area-minimised, resource-shared adder ALU that computes y = s ? (a+b) : (c+d).
- Uses one operand mux and one 1-bit full adder, iterated bit-serially over WIDTH cycles.
- It is the multi-cycle counterpart of the combinational shared-adder ALUs in the logic-minimisation chapter: it accepts one operation through a start/done handshake and returns the registered result.

Parameters:
- WIDTH, 4, operand and result width in bits; legal values are 2 to 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A; used when s=1.
- b  input  WIDTH  operand B; used when s=1.
- c  input  WIDTH  operand C; used when s=0.
- d  input  WIDTH  operand D; used when s=0.
- s  input  1  operand-pair select; sampled only together with an accepted start.
- start  input  1  request a new operation; single-cycle pulse or level.
- y  output  WIDTH  sum, low WIDTH bits.
- cout  output  1  carry out of the MSB.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: y and cout are valid from this cycle on.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - reset is synchronous and active-high.
  - When reset is sampled high: state=IDLE, y=0, cout=0, busy=0, done=0, internal shift registers, carry and counter all 0.
  - A reset sampled mid-operation aborts the operation. No done is issued for it, and y is cleared to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1: latch opx = s ? a : c and opy = s ? b : d into WIDTH-bit shift registers, then clear carry and cnt. Next state is SHIFT and busy=1.
  - Otherwise stay in IDLE.
- SHIFT (one bit per clock):
  - sum = opx[0] ^ opy[0] ^ carry.
  - carry <= majority(opx[0], opy[0], carry).
  - The result shift register shifts right with sum entering at the MSB; opx and opy shift right.
  - cnt increments each cycle.
  - On the cycle where cnt = WIDTH-1:
    - y <= completed result, including the final sum bit.
    - cout <= final carry.
    - done <= 1, busy <= 0, next state DONE.
- DONE:
  - done is high for exactly this one cycle.
  - If start=1 in DONE, the new operation is accepted exactly as in IDLE (back-to-back; next state SHIFT, busy=1).
  - Otherwise the next state is IDLE.
- Latency: if start is accepted at edge k, done is high in the cycle following edge k+WIDTH. That is WIDTH cycles of SHIFT; throughput is 1 operation per WIDTH+1 cycles.
- Output hold:
  - y and cout hold their value from the done cycle until the next operation's done cycle or reset.
  - They do not change during SHIFT.
  - The result is accumulated in an internal register and only transferred to y at completion.
- start while busy (SHIFT) is ignored; it is not queued.
- Operand inputs and s may change freely after acceptance; only the values latched at acceptance are used.
- Arithmetic is unsigned modulo 2^WIDTH, with the carry reported on cout.
- The counter is $clog2(WIDTH) bits wide.

Decomposition:
- Shared include file alu_serial_defs.vh:
  - State encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Select encoding SEL_CD=1'b0, SEL_AB=1'b1, shared with the combinational ALU benches.
- One sub-module, full_adder_bit:
  - Inputs x, y, cin; outputs sum, cout; purely combinational.
  - Instanced once, which makes the single shared adder explicit for area comparison.
- FSM, counter and shift registers live in alu_serial.

Test Plan:
- Reset with a=1, b=2, c=4, d=8 applied -> y=0, cout=0, busy=0, done=0. Repeat with reset held for 3 cycles -> no change.
- a=1, b=2, c=4, d=8, s=0, start pulse -> busy high for 4 cycles, then done for 1 cycle with y=12 (4'hC), cout=0. Rerun with s=1 -> y=3, cout=0. y must stay unchanged during SHIFT.
- a=15, b=1, s=1 -> y=0, cout=1. Then c=9, d=9, s=0 -> y=2, cout=1.
- Start held high continuously with operand pairs (1,2), (4,8), (15,15) and s=1 -> results 3, 12, 14 with cout=0, 0, 1. Each done is exactly 5 cycles after the previous one, and extra start cycles during SHIFT are ignored.
- Start accepted, then operands and s changed on the next cycle -> result reflects the latched values only.
- Reset asserted 2 cycles into an operation -> no done pulse, y=0, busy=0 on the following cycle. A new start then completes normally.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: shared state and operand-select encodings for the serial adder ALU
package alu_serial_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam logic SEL_CD = 1'b0;
  localparam logic SEL_AB = 1'b1;
endpackage

// File: rtl/alu_serial_full_adder_bit.sv
// full_adder_bit: the single 1-bit full adder shared across all bit positions
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/alu_serial.sv
// alu_serial: bit-serial y = s ? a+b : c+d using one operand mux and one full adder
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] opx, opy, res;
  logic [WIDTH-2:0] acc;
  logic [CW-1:0] cnt;
  logic carry, fa_sum, fa_cout, accept, last;
  full_adder_bit u_fa (
    .x   (opx[0]),
    .y   (opy[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );
  assign accept = start && state != ST_SHIFT;
  assign last   = state == ST_SHIFT && cnt == LAST;
  assign res    = {fa_sum, acc};
  assign busy   = state == ST_SHIFT;
  assign done   = state == ST_DONE;
  always_comb begin
    state_nx = accept ? ST_SHIFT : (state == ST_SHIFT && !last) ? ST_SHIFT : last ? ST_DONE : ST_IDLE;
  end
  // acc keeps the WIDTH-1 sums produced so far; the final sum completes y directly
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      opx   <= '0;
      opy   <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      y     <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        opx   <= s == SEL_AB ? a : c;
        opy   <= s == SEL_AB ? b : d;
        carry <= 1'b0;
        cnt   <= '0;
      end else if (state == ST_SHIFT) begin
        opx   <= opx >> 1;
        opy   <= opy >> 1;
        acc   <= res[WIDTH-1:1];
        carry <= fa_cout;
        cnt   <= cnt + CW'(1);
        if (last) begin
          y    <= res;
          cout <= fa_cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: randomized and directed checks of alu_serial against an arithmetic model
module tb_alu_serial;
  localparam int W = 4;
  logic clk = 1'b0, reset = 1'b1, s = 1'b0, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0, y;
  logic cout, busy, done;
  int checks = 0, errors = 0, cyc = 0;
  logic [W:0] exp_r = '0;

  alu_serial #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d), .s(s),
    .start(start), .y(y), .cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic sel, input logic [W-1:0] av, bv, cv, dv);
    int r;
    r = sel ? int'(av) + int'(bv) : int'(cv) + int'(dv);
    return (W + 1)'(r);
  endfunction

  task automatic wait_done(output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    check("done_timeout", done, 1);
    t = cyc;
  endtask

  task automatic run_op(input logic sel, input logic [W-1:0] av, bv, cv, dv);
    logic [W:0] e;
    e = model(sel, av, bv, cv, dv);
    @(negedge clk);
    a = av; b = bv; c = cv; d = dv; s = sel; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = ~av; b = W'($urandom); c = W'($urandom); d = ~dv; s = ~sel;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("busy", busy, 1);
      check("done_early", done, 0);
      check("y_hold", {cout, y}, exp_r);
    end
    @(negedge clk);
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("sum", {cout, y}, e);
    exp_r = e;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("y_keep", {cout, y}, e);
  endtask

  initial begin
    int t0, t1, t2;
    a = 4'd1; b = 4'd2; c = 4'd4; d = 4'd8;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_y", {cout, y}, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_y", {cout, y}, 0);

    run_op(1'b0, 4'd1, 4'd2, 4'd4, 4'd8);
    run_op(1'b1, 4'd1, 4'd2, 4'd4, 4'd8);
    run_op(1'b1, 4'd15, 4'd1, 4'd0, 4'd0);
    run_op(1'b0, 4'd0, 4'd0, 4'd9, 4'd9);

    // start held high: back-to-back operations, extra start cycles during SHIFT ignored
    @(negedge clk);
    a = 4'd1; b = 4'd2; s = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 a = 4'd4; b = 4'd8;
    wait_done(t0);
    check("b2b_0", {cout, y}, model(1'b1, 4'd1, 4'd2, 4'd0, 4'd0));
    @(posedge clk);
    #1 a = 4'd15; b = 4'd15;
    wait_done(t1);
    check("b2b_1", {cout, y}, model(1'b1, 4'd4, 4'd8, 4'd0, 4'd0));
    check("b2b_gap1", t1 - t0, W + 1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(t2);
    check("b2b_2", {cout, y}, 5'h1E);
    check("b2b_gap2", t2 - t1, W + 1);
    exp_r = 5'h1E;
    @(negedge clk);
    check("b2b_idle", busy, 0);

    // reset during an operation aborts it
    @(negedge clk);
    a = 4'd3; b = 4'd3; c = 4'd5; d = 4'd6; s = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_y", {cout, y}, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    exp_r = '0;
    repeat (W + 2) begin
      @(negedge clk);
      check("no_done", done, 0);
    end
    run_op(1'b0, 4'd3, 4'd3, 4'd5, 4'd6);

    for (int i = 0; i < 25; i++)
      run_op(1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
